sa_pq_r: RTL and testbench
==========================

# sa_pq_r

Systolic-array "reduced" priority queue that implements the responder side of `pq_if`: the block the PQ testbenches drive with `enq`/`deq`/`kvi`. Entries are key/value pairs. The smallest key has the highest priority, and equal keys leave in FIFO order. Each accepted operation takes one accept cycle followed by one update cycle, signalled on `busy`. The block is a drop-in alternative PQ under the existing bench and benchmarking harness.

## Interface
- `PQ_CAP`, 8, number of entries; 2..64.
- `KEY_WIDTH`, `pq_pkg::KEY_WIDTH`, key bits.
- `VAL_WIDTH`, `pq_pkg::VAL_WIDTH`, value bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `enq`  in  1  enqueue request.
- `deq`  in  1  dequeue request.
- `kvi`  in  KEY_WIDTH+VAL_WIDTH  enqueued entry, `{key,val}`.
- `kvo`  out  KEY_WIDTH+VAL_WIDTH  head entry; lowest key.
- `ovalid`  out  1  `kvo` holds a real entry; equals `!empty`.
- `busy`  out  1  update cycle in progress; requests are ignored.
- `empty`  out  1  count==0.
- `full`  out  1  count==PQ_CAP.
- `err`  out  2  `{ovf,udf}` sticky; present only with `SA_PQ_ERR_EN`.

## Operation
- FSM has two states.
  - `ACCEPT` (`busy`=0): an edge with `enq|deq` high latches the command and `kvi`, then moves to `UPDATE`. Otherwise stay in `ACCEPT`.
  - `UPDATE` (`busy`=1): the array performs the latched operation at the closing edge, then returns to `ACCEPT`. `enq`/`deq` sampled in `UPDATE` are dropped and never queued.
- Cells `0..PQ_CAP-1` each hold `{valid,kv}`. Cell 0 is the head. Valid cells are contiguous from 0 and sorted by ascending key.
- enq only:
  - Insert position = first cell whose key is strictly greater than the new key, or the first invalid cell. Using strictly-greater gives FIFO order among equal keys.
  - Cells at and after the insert position shift up by one.
- deq only: all cells shift down by one; the top cell becomes invalid.
- enq+deq:
  - The head is removed and the new entry is inserted in the same update. This works when full and leaves the count unchanged.
  - When empty, it behaves as enq only.
- enq when full without deq: dropped; contents unchanged.
- deq when empty: dropped.
- Count is a `$clog2(PQ_CAP+1)`-bit counter, kept consistent with the cell valid bits.
- `kvo` = cell 0 kv when valid, else all zeros.

## Timing
- Request at edge E, where `busy` was 0. Then `busy`=1 during E..E+1.
- At edge E+1 the new `kvo`, `empty`, `full` and `ovalid` are visible, and `busy` returns to 0.
- Operation latency is 2 edges. Maximum throughput is one operation per 2 cycles.
- The earliest next request is sampled at edge E+2.
- Reset (async assert, synchronous release):
  - FSM to `ACCEPT`; all cells invalid.
  - `kvo`=0, `ovalid`=0, `busy`=0, `empty`=1, `full`=0, `err`=0.
- Reset asserted during `UPDATE` aborts the operation; no partial shift is kept.
- Comparators are unsigned on the key field only; the value is never compared.

## Configuration
- `SA_PQ_ERR_EN` defined:
  - Adds the `err` port.
  - `ovf` sets when enq is dropped because the queue is full.
  - `udf` sets when deq is dropped because the queue is empty.
  - Both flags are sticky until reset.
- `SA_PQ_ERR_EN` undefined: no `err` port and no error logic. Drop behaviour is identical.

## Structure
- `pq_pkg` holds:
  - `KEY_WIDTH`, `VAL_WIDTH`;
  - `typedef struct packed {key; val} kv_t`;
  - `typedef enum {OP_NONE, OP_ENQ, OP_DEQ, OP_REPL} pq_op_t`.
- Sub-module `sa_pq_cell`:
  - Holds one entry and computes its local "new key < mine" compare.
  - Selects among hold, load from the lower neighbour, load new, load from the upper neighbour, or clear.
  - Generated `PQ_CAP` times in `sa_pq_r`.

## Test plan
- Reset: drive ops, then assert `rst`=0 mid-`UPDATE` → `empty`=1, `full`=0, `busy`=0, `ovalid`=0, `kvo`=0 immediately.
- Enqueue (8,14), (11,11), (9,9), (12,12) → `kvo`={8,14} after the first op. `busy` is high exactly one cycle per op. An enq driven during `busy` is ignored.
- Replace operations:
  - Continuing from the previous scenario, enq+deq (13,13) → head becomes {9,9}.
  - Then enq+deq (1,1) → head becomes {1,1}.
  - Then 4 deqs → heads {11,11}, {12,12}, {13,13}, empty.
- Tie order: enq (10,10), (10,3), (1,1) → deqs yield {1,1}, {10,10}, {10,3}, then `empty`=1.
- Full, with `PQ_CAP`=8:
  - Enq keys 8..1 → `full`=1.
  - Enq (0,0) → dropped; `ovf`=1 (macro on); head stays {1,*}.
  - enq+deq (0,0) → head becomes {0,0} and `full` stays 1.
- Empty: deq while empty → no change, `udf`=1 (macro on). enq+deq (5,5) while empty → `kvo`={5,5}, count 1.

Source files
------------

// File: rtl/pq_pkg.sv
// pq_pkg: shared key/value widths, entry struct and PQ operation codes
package pq_pkg;
   localparam int KEY_WIDTH = 8;
   localparam int VAL_WIDTH = 8;
   typedef struct packed {
      logic [KEY_WIDTH-1:0] key;
      logic [VAL_WIDTH-1:0] val;
   } kv_t;
   typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_REPL} pq_op_t;
endpackage

// File: rtl/pq_if.sv
// pq_if: priority-queue request/response bundle
//   master drives enq/deq/kvi; slave drives kvo/ovalid/busy/empty/full
interface pq_if #(
   parameter int KW = pq_pkg::KEY_WIDTH,
   parameter int VW = pq_pkg::VAL_WIDTH
);
   logic          enq;
   logic          deq;
   logic [KW+VW-1:0] kvi;
   logic [KW+VW-1:0] kvo;
   logic          ovalid;
   logic          busy;
   logic          empty;
   logic          full;
   modport master (output enq, deq, kvi, input kvo, ovalid, busy, empty, full);
   modport slave  (input enq, deq, kvi, output kvo, ovalid, busy, empty, full);
endinterface

// File: rtl/sa_pq_cell.sv
// sa_pq_cell: one systolic PQ cell holding {v,kv}
//   clk, rst (async active-low), upd: apply op this edge, op: effective operation,
//   nkv: entry being inserted, lo_*/up_*: lower/upper neighbour state and compare,
//   v/kv: stored entry, lt: cell is empty or its key is strictly greater than nkv.key
module sa_pq_cell import pq_pkg::*; #(
   parameter bit HEAD = 1'b0
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   upd,
   input  pq_op_t op,
   input  kv_t    nkv,
   input  logic   lo_v,
   input  kv_t    lo_kv,
   input  logic   lo_lt,
   input  logic   up_v,
   input  kv_t    up_kv,
   input  logic   up_lt,
   output logic   v,
   output kv_t    kv,
   output logic   lt
);
   logic ld_up, ld_lo, ld_new, nv;
   kv_t  nkv_d;
   assign lt = !v || (nkv.key < kv.key);
   // Replace is "drop head, then insert": the shifted-down image of this cell is the
   // upper neighbour, so the insert point is decided by up_lt and holding keeps the
   // entry that slides into the slot just below the insert point.
   assign ld_up  = op == OP_DEQ || (op == OP_REPL && !up_lt);
   assign ld_lo  = op == OP_ENQ && lt && lo_lt;
   assign ld_new = (op == OP_ENQ && lt && !lo_lt) || (op == OP_REPL && up_lt && (HEAD || !lt));
   always_comb begin
      nv    = ld_up ? up_v  : ld_lo ? lo_v  : ld_new ? 1'b1 : v;
      nkv_d = ld_up ? up_kv : ld_lo ? lo_kv : ld_new ? nkv  : kv;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v  <= 1'b0;
         kv <= '0;
      end else if (upd) begin
         v  <= nv;
         kv <= nkv_d;
      end
   end
endmodule

// File: rtl/sa_pq_r.sv
// sa_pq_r: reduced systolic-array priority queue (lowest key first, FIFO among ties)
//   clk, rst (async active-low), pq: pq_if slave port,
//   err {ovf,udf}: sticky drop flags, present only when SA_PQ_ERR_EN is defined
module sa_pq_r import pq_pkg::*; #(
   parameter int PQ_CAP    = 8,
   parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
   parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH
) (
   input logic clk,
   input logic rst,
`ifdef SA_PQ_ERR_EN
   output logic [1:0] err,
`endif
   pq_if.slave pq
);
   localparam int CW = $clog2(PQ_CAP + 1);
   typedef enum logic {ACCEPT, UPDATE} st_t;
   st_t st;
   pq_op_t op, eop;
   logic [KEY_WIDTH+VAL_WIDTH-1:0] lkv;
   logic [CW-1:0] cnt;
   logic empty_i, full_i, upd;
   // index 0 sits below the head, PQ_CAP+1 above the top: both read as empty slots
   logic va [PQ_CAP+2];
   logic la [PQ_CAP+2];
   kv_t  ka [PQ_CAP+2];
   assign empty_i = cnt == '0;
   assign full_i  = cnt == CW'(PQ_CAP);
   assign upd     = st == UPDATE;
   always_comb begin
      eop = (op == OP_ENQ && full_i) || (op == OP_DEQ && empty_i) ? OP_NONE :
            op == OP_REPL && empty_i ? OP_ENQ : op;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st  <= ACCEPT;
         op  <= OP_NONE;
         lkv <= '0;
         cnt <= '0;
      end else if (st == ACCEPT) begin
         if (pq.enq || pq.deq) begin
            op  <= pq.enq && pq.deq ? OP_REPL : pq.enq ? OP_ENQ : OP_DEQ;
            lkv <= pq.kvi;
            st  <= UPDATE;
         end
      end else begin
         cnt <= eop == OP_ENQ ? cnt + 1'b1 : eop == OP_DEQ ? cnt - 1'b1 : cnt;
         st  <= ACCEPT;
      end
   end
`ifdef SA_PQ_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err <= 2'b00;
      else if (upd) err <= err | {op == OP_ENQ && full_i, op == OP_DEQ && empty_i};
   end
`endif
   assign va[0] = 1'b0;
   assign la[0] = 1'b0;
   assign ka[0] = '0;
   assign va[PQ_CAP+1] = 1'b0;
   assign la[PQ_CAP+1] = 1'b1;
   assign ka[PQ_CAP+1] = '0;
   for (genvar g = 0; g < PQ_CAP; g++) begin : g_cell
      sa_pq_cell #(.HEAD(g == 0)) u_cell (
         .clk(clk), .rst(rst), .upd(upd), .op(eop), .nkv(kv_t'(lkv)),
         .lo_v(va[g]), .lo_kv(ka[g]), .lo_lt(la[g]),
         .up_v(va[g+2]), .up_kv(ka[g+2]), .up_lt(la[g+2]),
         .v(va[g+1]), .kv(ka[g+1]), .lt(la[g+1])
      );
   end
   assign pq.kvo    = va[1] ? ka[1] : '0;
   assign pq.ovalid = va[1];
   assign pq.busy   = upd;
   assign pq.empty  = empty_i;
   assign pq.full   = full_i;
endmodule

// File: tb/tb_sa_pq_r.sv
// tb_sa_pq_r: table-driven directed checks of sa_pq_r (PQ_CAP=8, 8-bit key/val)
module tb_sa_pq_r;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   pq_if pif ();
`ifdef SA_PQ_ERR_EN
   logic [1:0] err;
`endif
   sa_pq_r #(.PQ_CAP(8)) dut (
      .clk(clk),
      .rst(rst),
`ifdef SA_PQ_ERR_EN
      .err(err),
`endif
      .pq(pif)
   );
   int checks = 0;
   int failures = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   typedef struct {
      logic enq, deq, hold;
      logic [15:0] kv, ekvo;
      logic eempty, efull;
   } vec_t;
   vec_t tv[$];
   function automatic void add(input logic e, input logic d, input logic h, input logic [15:0] kv,
                               input logic [15:0] ekvo, input logic ee, input logic ef);
      tv.push_back('{e, d, h, kv, ekvo, ee, ef});
   endfunction
   function automatic logic [15:0] fk(input int k);
      logic [7:0] kk;
      kk = 8'(k);
      return {kk, kk + 8'h20};
   endfunction
   task automatic run_op(input vec_t t, input string tag);
      @(negedge clk);
      pif.enq = t.enq;
      pif.deq = t.deq;
      pif.kvi = t.kv;
      @(posedge clk);
      #1;
      chk({tag, " busy_hi"}, pif.busy, 1);
      if (!t.hold) begin
         pif.enq = 1'b0;
         pif.deq = 1'b0;
      end
      @(posedge clk);
      #1;
      pif.enq = 1'b0;
      pif.deq = 1'b0;
      chk({tag, " busy_lo"}, pif.busy, 0);
      chk({tag, " kvo"}, pif.kvo, t.ekvo);
      chk({tag, " empty"}, pif.empty, t.eempty);
      chk({tag, " full"}, pif.full, t.efull);
      chk({tag, " ovalid"}, pif.ovalid, !t.eempty);
   endtask
   initial begin
      pif.enq = 1'b0;
      pif.deq = 1'b0;
      pif.kvi = '0;
      // basic enqueue; the second op keeps enq high through busy to prove it is dropped
      add(1, 0, 0, 16'h080E, 16'h080E, 0, 0);
      add(1, 0, 1, 16'h0B0B, 16'h080E, 0, 0);
      add(1, 0, 0, 16'h0909, 16'h080E, 0, 0);
      add(1, 0, 0, 16'h0C0C, 16'h080E, 0, 0);
      add(1, 1, 0, 16'h0D0D, 16'h0909, 0, 0);
      add(1, 1, 0, 16'h0101, 16'h0101, 0, 0);
      add(0, 1, 0, 16'h0000, 16'h0B0B, 0, 0);
      add(0, 1, 0, 16'h0000, 16'h0C0C, 0, 0);
      add(0, 1, 0, 16'h0000, 16'h0D0D, 0, 0);
      add(0, 1, 0, 16'h0000, 16'h0000, 1, 0);
      // equal keys leave in arrival order
      add(1, 0, 0, 16'h0A0A, 16'h0A0A, 0, 0);
      add(1, 0, 0, 16'h0A03, 16'h0A0A, 0, 0);
      add(1, 0, 0, 16'h0101, 16'h0101, 0, 0);
      add(0, 1, 0, 16'h0000, 16'h0A0A, 0, 0);
      add(0, 1, 0, 16'h0000, 16'h0A03, 0, 0);
      add(0, 1, 0, 16'h0000, 16'h0000, 1, 0);
      // fill to capacity with descending keys, then overflow and replace while full
      for (int k = 8; k >= 1; k--) add(1, 0, 0, fk(k), fk(k), 0, k == 1);
      add(1, 0, 0, 16'h0000, fk(1), 0, 1);
      add(1, 1, 0, 16'h0000, 16'h0000, 0, 1);
      for (int k = 2; k <= 8; k++) add(0, 1, 0, 16'h0000, fk(k), 0, 0);
      add(0, 1, 0, 16'h0000, 16'h0000, 1, 0);
      // underflow and replace on an empty queue
      add(0, 1, 0, 16'h0000, 16'h0000, 1, 0);
      add(1, 1, 0, 16'h0505, 16'h0505, 0, 0);
      add(0, 1, 0, 16'h0000, 16'h0000, 1, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", pif.busy, 0);
      chk("rst empty", pif.empty, 1);
      chk("rst full", pif.full, 0);
      chk("rst ovalid", pif.ovalid, 0);
      chk("rst kvo", pif.kvo, 0);
`ifdef SA_PQ_ERR_EN
      chk("rst err", err, 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      foreach (tv[i]) run_op(tv[i], $sformatf("v%0d", i));
`ifdef SA_PQ_ERR_EN
      chk("err sticky", err, 2'b11);
`endif
      // reset in the middle of an update drops everything immediately
      run_op('{1, 0, 0, 16'h0303, 16'h0303, 0, 0}, "pre_rst");
      @(negedge clk);
      pif.enq = 1'b1;
      pif.kvi = 16'h0202;
      @(posedge clk);
      #1;
      chk("mid busy_hi", pif.busy, 1);
      rst = 1'b0;
      pif.enq = 1'b0;
      #1;
      chk("mid empty", pif.empty, 1);
      chk("mid full", pif.full, 0);
      chk("mid busy", pif.busy, 0);
      chk("mid ovalid", pif.ovalid, 0);
      chk("mid kvo", pif.kvo, 0);
`ifdef SA_PQ_ERR_EN
      chk("mid err", err, 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      run_op('{1, 0, 0, 16'h0707, 16'h0707, 0, 0}, "post_enq");
      run_op('{0, 1, 0, 16'h0000, 16'h0000, 1, 0}, "post_deq");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
